// File: rtl/apb_cfg_regbank.sv
// APB3 configuration register bank for the CSC / 2-D filter / ICSC pipeline.
// Define APB_CFG_SHADOW_EN for shadow registers with a frame-synchronous commit.
module apb_cfg_regbank #(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_FILTER = 2,
  parameter int KSIZE      = 5,
  parameter int COEF_W     = 10,
  parameter int BIAS_W     = 8,
  parameter int WAIT_CYC   = 0
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic [ADDR_WIDTH-1:0]                   i_PADDR,
  input  logic                                    i_PSEL,
  input  logic                                    i_PENABLE,
  input  logic                                    i_PWRITE,
  input  logic [31:0]                             i_PWDATA,
  output logic                                    o_PREADY,
  output logic [31:0]                             o_PRDATA,
  output logic                                    o_PSLVERR,
  input  logic                                    i_frame_start,
  output logic [9*COEF_W-1:0]                     o_csc_coef,
  output logic [9*COEF_W-1:0]                     o_icsc_coef,
  output logic [3*BIAS_W-1:0]                     o_csc_bias,
  output logic [3*BIAS_W-1:0]                     o_icsc_bias,
  output logic [NUM_FILTER*KSIZE*KSIZE*COEF_W-1:0] o_filter_coef,
  output logic [NUM_FILTER+1:0]                   o_bypass,
  output logic                                    o_commit_pending
);

  localparam int WPR    = (KSIZE + 2) / 3;
  localparam int NFW    = NUM_FILTER * KSIZE * WPR;
  localparam int NCOEF  = 18 + NUM_FILTER * KSIZE * KSIZE;
  localparam int W_BYP  = 252;
  localparam int W_CTRL = 253;
  localparam int W_STAT = 254;
  localparam int W_ID   = 255;

  // Coefficient e: 0..8 CSC, 9..17 ICSC, then filters in (f*KSIZE+r)*KSIZE+c order.
  function automatic int coef_word(int e);
    int fe;
    fe = e - 18;
    if (e < 9) return e / 3;
    if (e < 18) return 4 + (e - 9) / 3;
    return 8 + (fe / KSIZE) * WPR + (fe % KSIZE) / 3;
  endfunction

  function automatic int coef_lsb(int e);
    if (e < 18) return ((e % 9) % 3) * 10;
    return (((e - 18) % KSIZE) % 3) * 10;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;

  logic [NCOEF*COEF_W-1:0] sh_coef, act_coef, coef_src;
  logic [6*BIAS_W-1:0]     sh_bias, act_bias, bias_src;
  logic [NUM_FILTER+1:0]   sh_byp, act_byp, byp_src;
  logic                    rd_active, rd_sel, pending, err_flag;
  logic [31:0]             widx, rdata;
  logic                    mapped, dec_err, wr_fire, ctrl_wr, commit_wr;
  logic                    unused_ok;

  // A transfer starts on PSEL&PENABLE; o_PREADY is high for exactly one cycle
  // (DONE) with o_PRDATA/o_PSLVERR valid; writes commit at the end of DONE.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: if (i_PSEL && i_PENABLE) begin
        if (WAIT_CYC == 0) state_nx = S_DONE;
        else begin
          state_nx = S_WAIT;
          cnt_nx   = 4'(WAIT_CYC);
        end
      end
      S_WAIT: begin
        if (!i_PSEL) state_nx = S_IDLE;
        else if (cnt == 4'd1) state_nx = S_DONE;
        else cnt_nx = cnt - 4'd1;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  assign widx      = 32'(i_PADDR[ADDR_WIDTH-1:2]);
  assign mapped    = (widx < 32'(8 + NFW)) || (widx >= 32'(W_BYP) && widx <= 32'(W_ID));
  assign dec_err   = !mapped || (i_PADDR[1:0] != 2'b00) || (i_PWRITE && widx >= 32'(W_STAT));
  assign wr_fire   = (state == S_DONE) && i_PWRITE && !o_PSLVERR;
  assign ctrl_wr   = wr_fire && (widx == 32'(W_CTRL));
  assign commit_wr = ctrl_wr && i_PWDATA[0];
  assign unused_ok = ^i_PWDATA;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_coef   <= '0;
      sh_bias   <= '0;
      sh_byp    <= '0;
      rd_active <= 1'b0;
    end else if (wr_fire) begin
      for (int e = 0; e < NCOEF; e++)
        if (widx == coef_word(e)) sh_coef[e*COEF_W +: COEF_W] <= i_PWDATA[coef_lsb(e) +: COEF_W];
      for (int b = 0; b < 6; b++)
        if (widx == ((b < 3) ? 32'd3 : 32'd7)) sh_bias[b*BIAS_W +: BIAS_W] <= i_PWDATA[(b%3)*8 +: BIAS_W];
      if (widx == 32'(W_BYP)) sh_byp <= i_PWDATA[NUM_FILTER+1:0];
      if (ctrl_wr) rd_active <= i_PWDATA[1];
    end
  end

  // A new error wins over a simultaneous ERR_CLR.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_flag <= 1'b0;
    else if (state == S_DONE && o_PSLVERR) err_flag <= 1'b1;
    else if (ctrl_wr && i_PWDATA[2]) err_flag <= 1'b0;
  end

`ifdef APB_CFG_SHADOW_EN
  // Commit uses the pending value from before this edge, so a COMMIT landing
  // on a frame edge waits for the next one; active loads pre-write shadow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_coef <= '0;
      act_bias <= '0;
      act_byp  <= '0;
      pending  <= 1'b0;
    end else begin
      if (i_frame_start && pending) begin
        act_coef <= sh_coef;
        act_bias <= sh_bias;
        act_byp  <= sh_byp;
      end
      if (commit_wr) pending <= 1'b1;
      else if (i_frame_start) pending <= 1'b0;
    end
  end
  assign rd_sel = rd_active;
`else
  logic unused_ns;
  assign act_coef  = sh_coef;
  assign act_bias  = sh_bias;
  assign act_byp   = sh_byp;
  assign pending   = 1'b0;
  assign rd_sel    = 1'b1;
  assign unused_ns = i_frame_start ^ commit_wr;
`endif

  always_comb begin
    rdata    = '0;
    coef_src = rd_sel ? act_coef : sh_coef;
    bias_src = rd_sel ? act_bias : sh_bias;
    byp_src  = rd_sel ? act_byp  : sh_byp;
    for (int e = 0; e < NCOEF; e++)
      if (widx == coef_word(e)) rdata[coef_lsb(e) +: COEF_W] = coef_src[e*COEF_W +: COEF_W];
    for (int b = 0; b < 6; b++)
      if (widx == ((b < 3) ? 32'd3 : 32'd7)) rdata[(b%3)*8 +: BIAS_W] = bias_src[b*BIAS_W +: BIAS_W];
    case (widx)
      32'(W_BYP):  rdata[NUM_FILTER+1:0] = byp_src;
      32'(W_CTRL): rdata[1] = rd_active;
      32'(W_STAT): rdata[1:0] = {err_flag, pending};
      32'(W_ID):   rdata = {8'h01, 8'(NUM_FILTER), 8'(KSIZE), 8'(COEF_W)};
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_PRDATA  <= '0;
      o_PSLVERR <= 1'b0;
    end else if (state != S_DONE && state_nx == S_DONE) begin
      o_PSLVERR <= dec_err;
      o_PRDATA  <= (dec_err || i_PWRITE) ? '0 : rdata;
    end else begin
      o_PSLVERR <= 1'b0;
      o_PRDATA  <= '0;
    end
  end

  assign o_PREADY         = (state == S_DONE);
  assign o_csc_coef       = act_coef[0 +: 9*COEF_W];
  assign o_icsc_coef      = act_coef[9*COEF_W +: 9*COEF_W];
  assign o_filter_coef    = act_coef[18*COEF_W +: NUM_FILTER*KSIZE*KSIZE*COEF_W];
  assign o_csc_bias       = act_bias[0 +: 3*BIAS_W];
  assign o_icsc_bias      = act_bias[3*BIAS_W +: 3*BIAS_W];
  assign o_bypass         = act_byp;
  assign o_commit_pending = pending;

endmodule

// File: tb/tb_apb_cfg_regbank.sv
// Randomized bench for apb_cfg_regbank against a word-level model of the register map.
module tb_apb_cfg_regbank;
  localparam int AW = 10, NF = 3, K = 7, CW = 10, BW = 8, WC = 3;
  localparam int WPR = (K + 2) / 3;
  localparam int NFW = NF * K * WPR;
  localparam int NEL = NF * K * K;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [AW-1:0]        paddr = '0;
  logic                 psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0]          pwdata = '0;
  logic                 o_PREADY, o_PSLVERR;
  logic [31:0]          o_PRDATA;
  logic                 fs_r = 1'b0;
  logic [9*CW-1:0]      o_csc_coef, o_icsc_coef;
  logic [3*BW-1:0]      o_csc_bias, o_icsc_bias;
  logic [NEL*CW-1:0]    o_filter_coef;
  logic [NF+1:0]        o_bypass;
  logic                 o_commit_pending;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_sh[256];
  logic [31:0] m_act[256];
  logic        m_rd_act, m_pend, m_err;

  always #5 clk = ~clk;

  apb_cfg_regbank #(.ADDR_WIDTH(AW), .NUM_FILTER(NF), .KSIZE(K), .COEF_W(CW),
                    .BIAS_W(BW), .WAIT_CYC(WC)) dut (
    .clk(clk), .rstn(rstn), .i_PADDR(paddr), .i_PSEL(psel), .i_PENABLE(penable),
    .i_PWRITE(pwrite), .i_PWDATA(pwdata), .o_PREADY(o_PREADY), .o_PRDATA(o_PRDATA),
    .o_PSLVERR(o_PSLVERR), .i_frame_start(fs_r), .o_csc_coef(o_csc_coef),
    .o_icsc_coef(o_icsc_coef), .o_csc_bias(o_csc_bias), .o_icsc_bias(o_icsc_bias),
    .o_filter_coef(o_filter_coef), .o_bypass(o_bypass), .o_commit_pending(o_commit_pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (register map at word granularity) ----------------
  function automatic logic [31:0] fld(logic [31:0] word, int k, int width, int step);
    return (word >> (k * step)) & ((32'd1 << width) - 32'd1);
  endfunction

  function automatic logic [31:0] word_mask(int w);
    logic [31:0] m;
    m = '0;
    if (w < 8) begin
      for (int k = 0; k < 3; k++)
        m |= (w % 4 == 3) ? (((32'd1 << BW) - 32'd1) << (8 * k)) : (((32'd1 << CW) - 32'd1) << (10 * k));
    end else if (w < 8 + NFW) begin
      for (int k = 0; k < 3; k++)
        if (((w - 8) % WPR) * 3 + k < K) m |= ((32'd1 << CW) - 32'd1) << (10 * k);
    end else if (w == 252) m = (32'd1 << (NF + 2)) - 32'd1;
    return m;
  endfunction

  function automatic logic exp_err(logic [9:0] a, logic wr);
    int w;
    w = int'(a[9:2]);
    return !(w < 8 + NFW || w >= 252) || (a[1:0] != 2'b00) || (wr && w >= 254);
  endfunction

  function automatic logic [31:0] exp_read(logic [9:0] a);
    int w;
    w = int'(a[9:2]);
    if (w < 8 + NFW || w == 252) begin
`ifdef APB_CFG_SHADOW_EN
      return m_rd_act ? m_act[w] : m_sh[w];
`else
      return m_act[w];
`endif
    end
    if (w == 253) return {30'd0, m_rd_act, 1'b0};
    if (w == 254) return {30'd0, m_err, m_pend};
    return {8'h01, 8'(NF), 8'(K), 8'(CW)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_sh[i] = '0;
      m_act[i] = '0;
    end
    m_rd_act = 1'b0;
    m_pend = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_frame();
`ifdef APB_CFG_SHADOW_EN
    if (m_pend) begin
      m_act = m_sh;
      m_pend = 1'b0;
    end
`endif
  endtask

  task automatic model_edge(input logic [9:0] a, input logic wr, input logic [31:0] wd, input logic fs);
    int w;
    w = int'(a[9:2]);
    if (fs) model_frame();
    if (exp_err(a, wr)) m_err = 1'b1;
    else if (wr) begin
      if (w < 8 + NFW || w == 252) begin
        m_sh[w] = wd & word_mask(w);
`ifndef APB_CFG_SHADOW_EN
        m_act[w] = wd & word_mask(w);
`endif
      end
      if (w == 253) begin
        m_rd_act = wd[1];
        if (wd[2]) m_err = 1'b0;
`ifdef APB_CFG_SHADOW_EN
        if (wd[0]) m_pend = 1'b1;
`endif
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic xfer(input logic [9:0] a, input logic wr, input logic [31:0] wd, input logic fs);
    int n;
    logic e;
    e = exp_err(a, wr);
    exp_q.push_back((e || wr) ? 32'h0 : exp_read(a));
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!o_PREADY && n < 40);
    check("latency", 32'(n), 32'(1 + WC));
    check("prdata", o_PRDATA, exp_q.pop_front());
    check("pslverr", 32'(o_PSLVERR), 32'(e));
    if (fs) fs_r = 1'b1;
    @(posedge clk);
    model_edge(a, wr, wd, fs);
    #1;
    psel = 1'b0; penable = 1'b0; fs_r = 1'b0;
  endtask

  task automatic frame_pulse();
    @(posedge clk); #1;
    fs_r = 1'b1;
    @(posedge clk);
    model_frame();
    #1;
    fs_r = 1'b0;
  endtask

  task automatic check_outputs();
    int f, r, c;
    for (int i = 0; i < 9; i++) begin
      check("csc_coef", 32'(o_csc_coef[i*CW +: CW]), fld(m_act[i/3], i % 3, CW, 10));
      check("icsc_coef", 32'(o_icsc_coef[i*CW +: CW]), fld(m_act[4 + i/3], i % 3, CW, 10));
    end
    for (int k = 0; k < 3; k++) begin
      check("csc_bias", 32'(o_csc_bias[k*BW +: BW]), fld(m_act[3], k, BW, 8));
      check("icsc_bias", 32'(o_icsc_bias[k*BW +: BW]), fld(m_act[7], k, BW, 8));
    end
    for (int idx = 0; idx < NEL; idx++) begin
      f = idx / (K * K);
      r = (idx / K) % K;
      c = idx % K;
      check("filter_coef", 32'(o_filter_coef[idx*CW +: CW]),
            fld(m_act[8 + (f * K + r) * WPR + c / 3], c % 3, CW, 10));
    end
    check("bypass", 32'(o_bypass), m_act[252]);
    check("pending", 32'(o_commit_pending), 32'(m_pend));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    check("rst_pready", 32'(o_PREADY), 32'd0);
    check("rst_prdata", o_PRDATA, 32'd0);
    check("rst_pslverr", 32'(o_PSLVERR), 32'd0);
    check_outputs();

    xfer(10'h3FC, 1'b0, 32'h0, 1'b0);
    xfer(10'h000, 1'b1, 32'h3FF003FF, 1'b0);
    xfer(10'h000, 1'b0, 32'h0, 1'b0);
    check_outputs();
    xfer(10'h3F4, 1'b1, 32'h1, 1'b1);
    check_outputs();
    frame_pulse();
    check_outputs();
    check("csc_c0", 32'(o_csc_coef[9:0]), 32'h3FF);
    check("csc_c2", 32'(o_csc_coef[29:20]), 32'h3FF);

    xfer(10'h3F8, 1'b1, 32'h3, 1'b0);
    xfer(10'h202, 1'b0, 32'h0, 1'b0);
    xfer(10'h200, 1'b0, 32'h0, 1'b0);
    xfer(10'h3F8, 1'b0, 32'h0, 1'b0);
    xfer(10'h3F4, 1'b1, 32'h4, 1'b0);
    xfer(10'h3F8, 1'b0, 32'h0, 1'b0);

    xfer(10'h118, 1'b1, 32'h5, 1'b0);
    xfer(10'h3F4, 1'b1, 32'h1, 1'b0);
    frame_pulse();
    check("filt146", 32'(o_filter_coef[146*CW +: CW]), 32'h5);
    xfer(10'h3F0, 1'b1, 32'hF, 1'b0);
    check_outputs();
    xfer(10'h3F4, 1'b1, 32'h2, 1'b0);
    xfer(10'h3F0, 1'b0, 32'h0, 1'b0);
    xfer(10'h118, 1'b0, 32'h0, 1'b0);
    xfer(10'h3F4, 1'b1, 32'h0, 1'b0);

    // PSEL withdrawn during wait states: no completion, no register change.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 10'h004; pwrite = 1'b1; pwdata = 32'h1234567;
    @(posedge clk); #1 penable = 1'b1;
    repeat (2) @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_pready", 32'(o_PREADY), 32'd0);
    end
    xfer(10'h004, 1'b0, 32'h0, 1'b0);

    for (int t = 0; t < 300; t++) begin
      int sel, w, lo;
      logic [9:0] a;
      sel = $urandom_range(0, 9);
      lo = 0;
      case (sel)
        1, 2: w = 8 + $urandom_range(0, NFW - 1);
        3: w = 252;
        4: w = 253;
        5: w = 254;
        6: w = 255;
        7: w = $urandom_range(8 + NFW, 251);
        8: begin
          w = $urandom_range(0, 8 + NFW - 1);
          lo = $urandom_range(1, 3);
        end
        default: w = $urandom_range(0, 7);
      endcase
      a = 10'(w * 4 + lo);
      xfer(a, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 5) == 0) frame_pulse();
      if (t % 10 == 9) check_outputs();
    end

    // Reset during wait states aborts the transfer and clears everything.
    xfer(10'h3F4, 1'b1, 32'h1, 1'b0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 10'h3F0; pwrite = 1'b1; pwdata = 32'h1F;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rstn = 1'b0;
    #1;
    check("midrst_pready", 32'(o_PREADY), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    model_reset();
    check_outputs();
    xfer(10'h3F0, 1'b0, 32'h0, 1'b0);
    xfer(10'h3F8, 1'b0, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
